// File: rtl/fa_response_checker_if.sv
// Bundle of stimulus, response and result signals between a full-adder
// test driver and fa_response_checker.
interface fa_response_checker_if #(
    parameter int ERR_W = 8
) ();
    logic             start;
    logic             smp_valid;
    logic             a;
    logic             b;
    logic             cin;
    logic             s;
    logic             cout;
    logic             busy;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       cov_mask;
    logic [4:0]       first_err_vec;
    logic             first_err_valid;

    modport master (
        output start, smp_valid, a, b, cin, s, cout,
        input  busy, done, pass, timeout, mismatch,
        input  err_cnt, cov_mask, first_err_vec, first_err_valid
    );

    modport slave (
        input  start, smp_valid, a, b, cin, s, cout,
        output busy, done, pass, timeout, mismatch,
        output err_cnt, cov_mask, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/fa_response_checker.sv
// Response checker for a 1-bit full adder: aligns applied vectors with the
// adder's response, compares against the golden model and tracks coverage.
module fa_response_checker #(
    parameter int LATENCY = 0,
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst_n,
    fa_response_checker_if.slave bus
);

    localparam int PD    = (LATENCY == 0) ? 1 : LATENCY;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       pipe_q [PD];
    logic [3:0]       pipe_d [PD];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       cov_q, cov_d;
    logic [4:0]       ferr_vec_q, ferr_vec_d;
    logic             ferr_valid_q, ferr_valid_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic             mismatch_q, mismatch_d;

    logic [3:0]       cmp_entry;
    logic             cmp_valid;
    logic             exp_s;
    logic             exp_cout;
    logic             fail;
    logic             inflight;

    // Pipeline entries are {valid,a,b,cin}; it only advances while running
    // and is flushed by a start, so stale samples never reach a compare.
    always_comb begin
        for (int i = 0; i < PD; i++) begin
            pipe_d[i] = '0;
        end
        if ((LATENCY != 0) && (state_q == RUN) && !bus.start) begin
            pipe_d[0] = {bus.smp_valid, bus.a, bus.b, bus.cin};
            for (int i = 1; i < PD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
        inflight = 1'b0;
        for (int i = 0; i < PD; i++) begin
            inflight = inflight | pipe_d[i][3];
        end
    end

    always_comb begin
        cmp_entry = (LATENCY == 0) ? {bus.smp_valid, bus.a, bus.b, bus.cin}
                                   : pipe_q[PD-1];
        cmp_valid = (state_q == RUN) && !bus.start && cmp_entry[3];
        exp_s     = cmp_entry[2] ^ cmp_entry[1] ^ cmp_entry[0];
        exp_cout  = (cmp_entry[2] & cmp_entry[1]) | (cmp_entry[2] & cmp_entry[0]) |
                    (cmp_entry[1] & cmp_entry[0]);
        fail      = cmp_valid && ((bus.s != exp_s) || (bus.cout != exp_cout));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_cnt_d    = err_cnt_q;
        cov_d        = cov_q;
        ferr_vec_d   = ferr_vec_q;
        ferr_valid_d = ferr_valid_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        mismatch_d   = 1'b0;

        if (bus.start) begin
            state_d      = RUN;
            cnt_d        = '0;
            err_cnt_d    = '0;
            cov_d        = '0;
            ferr_vec_d   = '0;
            ferr_valid_d = 1'b0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cmp_valid) begin
                        cov_d[cmp_entry[2:0]] = 1'b1;
                        if (fail) begin
                            mismatch_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + 1'b1;
                            end
                            if (!ferr_valid_q) begin
                                ferr_vec_d   = {cmp_entry[2:0], bus.s, bus.cout};
                                ferr_valid_d = 1'b1;
                            end
                        end
                    end
                    // Normal completion is checked first so it wins a tie with timeout.
                    if ((cov_d == 8'hFF) && !inflight) begin
                        state_d = DONE;
                        pass_d  = (err_cnt_d == '0);
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        pass_d    = 1'b0;
                    end
                end
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_cnt_q    <= '0;
            cov_q        <= '0;
            ferr_vec_q   <= '0;
            ferr_valid_q <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_cnt_q    <= err_cnt_d;
            cov_q        <= cov_d;
            ferr_vec_q   <= ferr_vec_d;
            ferr_valid_q <= ferr_valid_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            mismatch_q   <= mismatch_d;
            for (int i = 0; i < PD; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.busy            = (state_q == RUN);
    assign bus.done            = (state_q == DONE);
    assign bus.pass            = pass_q;
    assign bus.timeout         = timeout_q;
    assign bus.mismatch        = mismatch_q;
    assign bus.err_cnt         = err_cnt_q;
    assign bus.cov_mask        = cov_q;
    assign bus.first_err_vec   = ferr_vec_q;
    assign bus.first_err_valid = ferr_valid_q;

endmodule

// File: doc/fa_response_checker.md
Name: fa_response_checker

Overview:
- Synthesizable response checker for a 1-bit full adder. It is the receiving end of the full-adder stimulus path.
- Samples the applied A/B/Cin vector and the DUT's S/Cout, aligned by a configurable DUT latency.
- Compares the response against the golden sum/carry and tracks coverage of all 8 input combinations.
- Reports pass/fail, error count, first failing vector and timeout. Sits beside the full adder in self-test wrappers and on-board test builds.

Parameters:
LATENCY, 0, DUT response latency in clk cycles (0..7); 0 = same-cycle compare
ERR_W, 8, width of error counter
TIMEOUT, 1024, max cycles in RUN before forced finish (>=16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse; begins/restarts a check run
smp_valid  input  1  a/b/cin valid this cycle (vector being applied)
a  input  1  applied operand A
b  input  1  applied operand B
cin  input  1  applied carry-in
s  input  1  DUT sum output
cout  input  1  DUT carry output
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  valid when done; 1 = full coverage, zero errors, no timeout
timeout  output  1  run ended by TIMEOUT
mismatch  output  1  one-cycle pulse on each failing compare
err_cnt  output  ERR_W  number of failing compares, saturating
cov_mask  output  8  bit {a,b,cin} set once that vector has been compared
first_err_vec  output  5  {a,b,cin,s,cout} of first failing compare
first_err_valid  output  1  first_err_vec holds a capture

Behaviour:
- Reset (rst_n low at clk edge):
  - State IDLE.
  - All outputs 0; err_cnt=0, cov_mask=0, first_err_vec=0.
  - Alignment pipeline and cycle counter cleared.
- Alignment:
  - {valid,a,b,cin} pass through a LATENCY-deep register pipeline.
  - Compare occurs in the cycle the delayed valid is high, using that cycle's s/cout.
  - LATENCY=0: compare uses the current-cycle inputs directly.
- Golden model: exp_s = a^b^cin; exp_cout = (a&b)|(a&cin)|(b&cin), on delayed operands.
- FSM states IDLE, RUN, DONE:
  - IDLE: ignore samples. start -> RUN.
  - Entering RUN (cycle after start):
    - Clear err_cnt, cov_mask, first_err_*, pass, timeout, cycle counter and alignment pipeline.
    - The first sample accepted is the one with smp_valid high in the cycle after start.
  - RUN: per compare:
    - Set cov_mask[{a,b,cin}].
    - On mismatch: pulse mismatch (registered, 1 cycle after the compare) and increment err_cnt (saturates at all-ones).
    - If first_err_valid=0, capture first_err_vec and set first_err_valid.
    - Repeated vectors are re-checked; each failing repeat is counted.
  - RUN -> DONE (normal): cov_mask reaches 8'hFF and the pipeline holds no valid entries. pass = (err_cnt==0).
  - RUN -> DONE (timeout): cycle counter reaches TIMEOUT-1 first. timeout=1, pass=0. In-flight compares are dropped.
  - If both conditions fall in the same cycle, the normal completion wins and timeout stays 0.
  - DONE: done=1; all results held stable; samples ignored. start -> RUN (results clear as above).
  - start during RUN: restart; discard in-progress results and pipeline.
- rst_n low mid-run overrides everything, including a simultaneous start.
- done, busy, pass and timeout are registered. done and busy are never high together.

Test Plan:
- LATENCY=0, correct adder, Gray-order vectors 000,100,110,010,011,111,101,001 one per cycle after start -> done=1 one cycle after the last compare; pass=1, err_cnt=0, cov_mask=8'hFF.
- LATENCY=2, DUT model forced cout=0 -> mismatch pulses for vectors 110, 111, 011, 101. Expected results:
  - err_cnt=4, pass=0.
  - first_err_vec = {1,1,0,0,0} = 5'b11000, for the first failing vector 110 (s=0, cout=0).
- Only 7 distinct vectors applied (011 never) -> busy stays 1 until TIMEOUT. Then done=1, timeout=1, pass=0, cov_mask=8'hF7.
- ERR_W=2, s stuck at 1, 8 vectors repeated twice -> err_cnt saturates at 3, no wrap. pass=0.
- start pulsed in the middle of a failing run -> err_cnt, cov_mask and first_err_valid are 0 the next cycle. A subsequent clean 8-vector sequence gives pass=1.
- rst_n low for 1 cycle while in RUN with err_cnt=2 -> all outputs 0 next cycle, state IDLE. Samples after reset are ignored until start.
